uart_rx: RTL

//   UART receiver paired with the team's UART transmitter. Fixed 8n1 framing, LSB first.

---
 rtl/uart_rx.sv | 83 ++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8n1 LSB-first UART receiver with 2-FF input synchroniser and centre-of-bit sampling
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_rx         raw serial line, idle high
//   o_rx_data    last good byte, held until the next good byte
//   o_rx_valid   one-cycle strobe, o_rx_data new this cycle
//   o_rx_busy    high whenever the receiver is not idle
//   o_frame_err  one-cycle strobe, stop bit sampled low
module uart_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_busy,
  output logic       o_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HC = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] BC = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  assign o_rx_busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, i_rx};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      o_rx_data <= '0;
      o_rx_valid <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            cnt <= HC;
          end
        START:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s) state <= IDLE;
          else begin
            state <= DATA;
            cnt <= BC;
            idx <= '0;
          end
        DATA:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            sh[idx] <= rx_s;
            cnt <= BC;
            if (idx == 3'd7) state <= STOP;
            else idx <= idx + 3'd1;
          end
        STOP:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s) begin
            o_rx_data <= sh;
            o_rx_valid <= 1'b1;
            state <= IDLE;
          end else begin
            o_frame_err <= 1'b1;
            state <= BREAK;
          end
        BREAK:
          if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
